// File: rtl/memarb_pkg.sv
// Shared types and widths for the instruction/data memory arbiter.
package memarb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arbStateT;

endpackage

// File: rtl/memarb_timer.sv
// Access timeout counter: counts stalled BUSY cycles and flags the cycle that reaches the limit.
module memarb_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The current stalled cycle is the TIMEOUT_CYC-th one when the count of earlier ones is one short.
  assign expired = enable && (cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch vs load/store) in front of one single-port memory.
// Define MEMARB_TIMEOUT_EN to abort accesses that see no mem_ready for TIMEOUT_CYC cycles.
module mem_arbiter
  import memarb_pkg::*;
#(
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [BE_W-1:0]   d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [BE_W-1:0]   mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        dbgState,
  output logic [7:0]        dbgStarveCnt
);

  localparam int SCNT_W = $clog2(STARVE_MAX + 1);

  if (STARVE_MAX < 1 || STARVE_MAX > 255 || TIMEOUT_CYC < 1) begin : gBadParam
    $error("mem_arbiter: STARVE_MAX must be 1..255 and TIMEOUT_CYC at least 1");
  end

  // Handshake: a requester raises x_req with its payload and holds both until the
  // cycle where x_valid=1; that cycle completes the access. Payload is sampled only
  // at the grant edge, so changes while BUSY have no effect.

  arbStateT          state, nextState;
  logic [SCNT_W-1:0] starveCnt;
  logic [ADDR_W-1:0] latAddr;
  logic              latWe;
  logic [BE_W-1:0]   latBe;
  logic [DATA_W-1:0] latWdata;
  logic              starveHit, pickI, grantI, grantD, timedOut, finish;

  assign starveHit = (starveCnt == SCNT_W'(STARVE_MAX));
  assign pickI     = i_req && (!d_req || starveHit);

  always_comb begin
    nextState = state;
    grantI    = 1'b0;
    grantD    = 1'b0;
    case (state)
      IDLE: begin
        if (pickI) begin
          grantI    = 1'b1;
          nextState = BUSY_I;
        end else if (d_req) begin
          grantD    = 1'b1;
          nextState = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        if (finish) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      starveCnt <= '0;
      latAddr   <= '0;
      latWe     <= 1'b0;
      latBe     <= '0;
      latWdata  <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE) begin
        if (grantI || !i_req) begin
          starveCnt <= '0;
        end else if (grantD && !starveHit) begin
          starveCnt <= starveCnt + 1'b1;
        end
      end
      if (grantI) begin
        latAddr  <= i_addr;
        latWe    <= 1'b0;
        latBe    <= '1;
        latWdata <= '0;
      end else if (grantD) begin
        latAddr  <= d_addr;
        latWe    <= d_we;
        latBe    <= d_be;
        latWdata <= d_wdata;
      end
    end
  end

`ifdef MEMARB_TIMEOUT_EN
  // Held clear while IDLE so every access starts counting from zero.
  memarb_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) uTimer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == IDLE),
    .enable  ((state != IDLE) && !mem_ready),
    .expired (timedOut)
  );
  assign i_err = (state == BUSY_I) && timedOut;
  assign d_err = (state == BUSY_D) && timedOut;
`else
  assign timedOut = 1'b0;
  assign i_err    = 1'b0;
  assign d_err    = 1'b0;
`endif

  assign finish    = mem_ready || timedOut;
  assign mem_req   = (state == BUSY_I) || (state == BUSY_D);
  assign mem_we    = latWe;
  assign mem_be    = latBe;
  assign mem_addr  = latAddr;
  assign mem_wdata = latWdata;

  // timedOut is only raised when mem_ready is low, so a late ready completes normally.
  assign i_valid = (state == BUSY_I) && finish;
  assign d_valid = (state == BUSY_D) && finish;
  assign i_rdata = timedOut ? '0 : mem_rdata;
  assign d_rdata = timedOut ? '0 : mem_rdata;

  assign dbgState     = state;
  assign dbgStarveCnt = 8'(starveCnt);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single accesses, priority, starvation, timeout, reset abort.
module tb_mem_arbiter;
  import memarb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_valid, i_err;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_valid, d_err;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [1:0]  dbgState;
  logic [7:0]  dbgStarveCnt;

  int checkCnt = 0;
  int errCnt = 0;
  logic [31:0] expQ[$];

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .dbgState(dbgState), .dbgStarveCnt(dbgStarveCnt)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Waits for mem_req, captures the access, answers with mem_ready in the first BUSY cycle.
  task automatic serve(input logic [31:0] rdata, output int waited,
                       output logic [31:0] addr, output logic we, output logic [3:0] be,
                       output logic [31:0] wdata, output logic iv, output logic dv,
                       output logic [31:0] ird, output logic [31:0] drd);
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!mem_req && waited < 20);
    checkVal("serve_req_seen", 32'(mem_req), 32'd1);
    addr = mem_addr; we = mem_we; be = mem_be; wdata = mem_wdata;
    mem_rdata = rdata;
    mem_ready = 1'b1;
    #1;
    iv = i_valid; dv = d_valid; ird = i_rdata; drd = d_rdata;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    logic [31:0] addr, wdata, ird, drd, expAddr;
    logic we, iv, dv;
    logic [3:0] be;
    int validAt;
    logic errSeen;
    logic [31:0] rdSeen;

    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_mem_req", 32'(mem_req), 32'd0);
    checkVal("rst_state", 32'(dbgState), 32'(IDLE));
    checkVal("rst_valids", {30'd0, i_valid, d_valid}, 32'd0);
    checkVal("rst_errs", {30'd0, i_err, d_err}, 32'd0);
    checkVal("rst_starve", 32'(dbgStarveCnt), 32'd0);
    checkVal("rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single fetch, two-cycle access.
    i_req = 1'b1; i_addr = 32'h100;
    serve(32'h00500093, waited, addr, we, be, wdata, iv, dv, ird, drd);
    i_req = 1'b0;
    checkVal("f_wait", 32'(waited), 32'd1);
    checkVal("f_addr", addr, 32'h100);
    checkVal("f_we", 32'(we), 32'd0);
    checkVal("f_be", 32'(be), 32'hF);
    checkVal("f_ivalid", 32'(iv), 32'd1);
    checkVal("f_dvalid", 32'(dv), 32'd0);
    checkVal("f_rdata", ird, 32'h00500093);
    checkVal("f_idle", 32'(dbgState), 32'(IDLE));
    checkVal("f_idle_req", 32'(mem_req), 32'd0);

    // mem_ready while IDLE is ignored.
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    #1;
    checkVal("idle_ready_valid", {30'd0, i_valid, d_valid}, 32'd0);
    @(posedge clk); #1;
    checkVal("idle_ready_state", 32'(dbgState), 32'(IDLE));
    mem_ready = 1'b0; mem_rdata = '0;

    // Simultaneous requests: store first, fetch after one IDLE cycle.
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
    i_req = 1'b1; i_addr = 32'h200;
    serve(32'h0, waited, addr, we, be, wdata, iv, dv, ird, drd);
    d_req = 1'b0; d_we = 1'b0;
    checkVal("st_addr", addr, 32'h2000);
    checkVal("st_we", 32'(we), 32'd1);
    checkVal("st_be", 32'(be), 32'hF);
    checkVal("st_wdata", wdata, 32'hDEADBEEF);
    checkVal("st_valids", {30'd0, iv, dv}, 32'd1);
    checkVal("st_starve", 32'(dbgStarveCnt), 32'd1);
    serve(32'h00000013, waited, addr, we, be, wdata, iv, dv, ird, drd);
    i_req = 1'b0;
    checkVal("f2_wait", 32'(waited), 32'd1);
    checkVal("f2_addr", addr, 32'h200);
    checkVal("f2_valids", {30'd0, iv, dv}, 32'd2);
    checkVal("f2_rdata", ird, 32'h00000013);

    // Starvation override: D,D,D,D,I,D.
    d_req = 1'b1; d_we = 1'b0; d_be = 4'h3; d_addr = 32'h3000;
    i_req = 1'b1; i_addr = 32'h400;
    expQ.push_back(32'h3000); expQ.push_back(32'h3000); expQ.push_back(32'h3000);
    expQ.push_back(32'h3000); expQ.push_back(32'h400);  expQ.push_back(32'h3000);
    for (int n = 0; n < 6; n++) begin
      if (n == 4) checkVal("sv_starve_sat", 32'(dbgStarveCnt), 32'd4);
      serve(32'hA000 + 32'(n), waited, addr, we, be, wdata, iv, dv, ird, drd);
      expAddr = expQ.pop_front();
      checkVal($sformatf("sv_wait%0d", n), 32'(waited), 32'd1);
      checkVal($sformatf("sv_addr%0d", n), addr, expAddr);
      checkVal($sformatf("sv_ivalid%0d", n), 32'(iv), (expAddr == 32'h400) ? 32'd1 : 32'd0);
      checkVal($sformatf("sv_rdata%0d", n), (expAddr == 32'h400) ? ird : drd, 32'hA000 + 32'(n));
    end
    d_req = 1'b0; i_req = 1'b0;
    @(posedge clk); #1;
    checkVal("sv_starve_clr", 32'(dbgStarveCnt), 32'd0);

    // Stalled memory: timeout abort or indefinite wait.
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h5000;
    mem_rdata = 32'hAAAA5555;
    validAt = 0; errSeen = 1'b0; rdSeen = '0;
    @(posedge clk); #1;
    for (int k = 1; k <= 300; k++) begin
      if (d_valid) begin
        validAt = k; errSeen = d_err; rdSeen = d_rdata;
        break;
      end
      @(posedge clk); #1;
    end
`ifdef MEMARB_TIMEOUT_EN
    checkVal("to_cycle", 32'(validAt), 32'd255);
    checkVal("to_err", 32'(errSeen), 32'd1);
    checkVal("to_rdata", rdSeen, 32'd0);
    @(posedge clk); #1;
    d_req = 1'b0;
    checkVal("to_idle", 32'(dbgState), 32'(IDLE));
`else
    checkVal("nto_novalid", 32'(validAt), 32'd0);
    checkVal("nto_busy", 32'(dbgState), 32'(BUSY_D));
    checkVal("nto_req", 32'(mem_req), 32'd1);
    mem_ready = 1'b1;
    #1;
    checkVal("nto_done", {30'd0, d_valid, d_err}, 32'd2);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    d_req = 1'b0;
`endif
    mem_rdata = '0;
    @(posedge clk); #1;

    // Reset during BUSY_D abandons the access.
    i_req = 1'b1; i_addr = 32'h700;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h6000; d_wdata = 32'h1;
    @(posedge clk); #1;
    checkVal("ra_busy", 32'(dbgState), 32'(BUSY_D));
    checkVal("ra_starve_pre", 32'(dbgStarveCnt), 32'd1);
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    checkVal("ra_mem_req", 32'(mem_req), 32'd0);
    checkVal("ra_dvalid", 32'(d_valid), 32'd0);
    checkVal("ra_starve", 32'(dbgStarveCnt), 32'd0);
    checkVal("ra_state", 32'(dbgState), 32'(IDLE));
    mem_ready = 1'b0;
    d_req = 1'b0; d_we = 1'b0;
    i_addr = 32'h600;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checkVal("ra_regrant_state", 32'(dbgState), 32'(BUSY_I));
    checkVal("ra_regrant_addr", mem_addr, 32'h600);
    mem_ready = 1'b1; mem_rdata = 32'h13;
    #1;
    checkVal("ra_ivalid", 32'(i_valid), 32'd1);
    checkVal("ra_irdata", i_rdata, 32'h13);
    @(posedge clk); #1;
    mem_ready = 1'b0; i_req = 1'b0;
    checkVal("ra_end_idle", 32'(dbgState), 32'(IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning the maximum number of consecutive data grants while an instruction request waits.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255, meaning the number of BUSY cycles without mem_ready before abort (used only with MEMARB_TIMEOUT_EN).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports i_req (in, 1) and i_addr (in, 32) for the instruction-fetch request and its word address.
REQ-006 SHALL have ports i_rdata (out, 32), i_valid (out, 1) and i_err (out, 1) for the fetch completion.
REQ-007 SHALL have ports d_req (in, 1), d_we (in, 1), d_be (in, 4), d_addr (in, 32) and d_wdata (in, 32) for the load/store request.
REQ-008 SHALL have ports d_rdata (out, 32), d_valid (out, 1) and d_err (out, 1) for the load/store completion.
REQ-009 SHALL have ports mem_req (out, 1), mem_we (out, 1), mem_be (out, 4), mem_addr (out, 32) and mem_wdata (out, 32) to the shared single-port memory.
REQ-010 SHALL have ports mem_rdata (in, 32) and mem_ready (in, 1) from the memory; mem_ready marks the completing cycle.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY_I and BUSY_D.
REQ-012 IDLE SHALL select a requester at the clock edge: d_req over i_req, except the starvation override of REQ-017; with no request, stay IDLE.
REQ-013 On a grant, the block SHALL latch the granted address, we, be and wdata into registers (instruction grant: we=0, be=4'hF, wdata=0).
REQ-014 mem_req SHALL be 1 exactly in BUSY_I and BUSY_D, and mem_* outputs SHALL be driven only from the latched registers, stable for the whole access.
REQ-015 In BUSY_x with mem_ready=1, x_valid SHALL be 1 in that same cycle (combinational), x_rdata SHALL equal mem_rdata, and the FSM SHALL go to IDLE at the next edge.
REQ-016 Minimum access time SHALL be 2 cycles (IDLE grant plus one BUSY cycle); back-to-back accesses SHALL have exactly one IDLE cycle between them.
REQ-017 starve_cnt SHALL increment on each data grant made while i_req=1, and SHALL clear on an instruction grant or on any IDLE arbitration with i_req=0; at starve_cnt==STARVE_MAX, a pending i_req SHALL win over d_req.
REQ-018 starve_cnt SHALL saturate at STARVE_MAX.
REQ-019 Requesters SHALL hold req and payload until valid; the block SHALL ignore payload changes during BUSY.
REQ-020 d_rdata SHALL be don't-care on write completion, but d_valid SHALL still pulse.
REQ-021 i_valid and d_valid SHALL never be 1 together, and SHALL be 0 outside BUSY.
REQ-022 mem_ready while IDLE SHALL be ignored.

Reset
REQ-023 reset=1 SHALL force IDLE, starve_cnt=0, timeout counter=0, latched registers=0, mem_req=0, valids=0 and errs=0, asynchronously.
REQ-024 Reset during BUSY SHALL abandon the access with no valid pulse; the first grant SHALL be possible on the first edge after deassertion.

Configuration
REQ-025 With MEMARB_TIMEOUT_EN defined, a counter SHALL count BUSY cycles with mem_ready=0; on reaching TIMEOUT_CYC, x_valid=1, x_err=1 and x_rdata=0 SHALL be output for one cycle and the FSM SHALL return to IDLE.
REQ-026 The timeout counter SHALL clear on entry to BUSY; mem_ready in the timeout cycle SHALL take precedence (normal completion, err=0).
REQ-027 Without MEMARB_TIMEOUT_EN, the block SHALL wait indefinitely, i_err and d_err SHALL be tied to 0, and no counter SHALL be synthesized.

Structure
REQ-028 Shared package memarb_pkg SHALL hold the FSM state encoding (2 bits), ADDR_W=32, DATA_W=32 and BE_W=4.
REQ-029 The timeout counter SHALL be sub-module memarb_timer (clear, enable, expired), instantiated only under MEMARB_TIMEOUT_EN.

Verification
REQ-030 i_req=1 (i_addr=0x100) only, mem_ready one cycle after mem_req with mem_rdata=0x00500093 -> mem_addr=0x100, mem_we=0; i_valid=1 with i_rdata=0x00500093 in the 2nd cycle.
REQ-031 d_req=1 and i_req=1 in the same cycle, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF -> data is served first (mem_we=1, mem_be=4'hF), then the fetch after one IDLE cycle.
REQ-032 d_req and i_req held high for 6 accesses with STARVE_MAX=4 -> grant order D,D,D,D,I,D.
REQ-033 mem_ready held low for 300 cycles, MEMARB_TIMEOUT_EN defined, TIMEOUT_CYC=255 -> d_valid=1, d_err=1, d_rdata=0 after 255 BUSY cycles, then IDLE; undefined build -> still BUSY at 300 cycles.
REQ-034 reset pulsed mid-BUSY_D -> mem_req=0 immediately, no d_valid, starve_cnt=0; a fresh i_req is granted on the first edge after release.
